data_sram_bridge: RTL and testbench
===================================

# data_sram_bridge

Memory-stage bridge between the pipeline's M-stage data access (byte address, write-enable lanes, store data, load size) and a split-transaction SRAM-like data bus with independent address and data handshakes. It issues exactly one bus transaction per memory instruction, stalls the pipeline until the response arrives, aligns store data and strobes onto byte lanes, and right-justifies load data so byte/half extraction in W uses bits [7:0]/[15:0]. It sits directly downstream of the datapath's M-stage pipeline register and feeds `readdataM` and a stall request to the hazard unit.

## Interface
Parameters:
- AW, 32, bus and request address width
- DW, 32, data width (fixed 4 byte lanes)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- memenM  in  1  M-stage instruction is a load or store
- mem_wenM  in  4  store lanes: 0001 SB, 0011 SH, 1111 SW, 0000 load
- loadsizeM  in  2  load size: 0 byte, 1 half, 2 word (ignored for stores)
- mem_addrM  in  AW  byte address
- writedataM  in  DW  unaligned store data (value in low bits)
- flushM  in  1  M-stage instruction is being squashed
- stall_extM  in  1  another source is stalling M
- readdataM  out  DW  right-justified load data, valid in DONE
- stall_memM  out  1  stall request to hazard unit
- adelM  out  1  load address error pulse
- adesM  out  1  store address error pulse
- data_req  out  1  bus request valid
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  AW  byte address
- data_wdata  out  DW  lane-replicated store data
- data_wstrb  out  4  byte strobes
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  DW  raw bus word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: on memenM & ~flushM & ~misalign -> REQ (bus fields registered from M inputs). Else stay.
- REQ: data_req=1; on data_addr_ok -> WAIT; on flushM before addr_ok -> IDLE, data_req drops next cycle. addr_ok and flushM together: accepted, go DRAIN.
- WAIT: on data_data_ok -> DONE, capture aligned rdata; on flushM -> DRAIN (data_ok with flushM same cycle -> IDLE, data discarded).
- DRAIN: data_req=0; wait for data_data_ok, discard, -> IDLE. stall_memM=0.
- DONE: stall_memM=0; readdataM held; if stall_extM stay DONE, else -> IDLE.
- stall_memM = memenM&~misalign&~flushM in IDLE, 1 in REQ/WAIT, 0 in DONE/DRAIN.
- Store size from mem_wenM: 0001->0, 0011->1, 1111->2; load size from loadsizeM.
- data_wstrb = mem_wenM << addr[1:0] (loads: 0000). data_wdata: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- readdataM: byte rdata>>(8*addr[1:0]), half rdata>>(16*addr[1]), word rdata; upper bits zero.
- data_data_ok in IDLE/DONE ignored.

## Timing
- Reset: state IDLE; all outputs 0 (readdataM=0, data_req=0, flags 0). Reset mid-transaction abandons it; stray data_ok after reset ignored.
- data_req first high the cycle after memenM seen in IDLE; bus fields stable while data_req=1.
- Minimum load latency: memenM cycle + REQ + WAIT + DONE; zero-wait bus (addr_ok in REQ, data_ok first WAIT cycle) releases pipeline 3 cycles after memenM.
- readdataM valid only in DONE; pipeline W register captures at DONE's edge.
- One transaction in flight at most; no new REQ while in DRAIN.

## Configuration
- DSRAM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 raises adelM (load) or adesM (store) for one cycle in IDLE, no bus request, no stall.
- Undefined: adelM/adesM tied 0; low address bits forced to natural alignment (addr[0]=0 for half, addr[1:0]=0 for word) and access issued.

## Structure
- Shared package/defines: state encodings, size codes (BYTE/HALF/WORD), strobe constants 0001/0011/1111.
- One sub-module natural: `dsram_lane_align` (combinational strobe/wdata replication and rdata right-justification).

## Test plan
- SW addr 0x10, wd 0xDEADBEEF, zero-wait bus -> data_wstrb 1111, data_size 2, stall_memM high 2 cycles, data_req high exactly 1 cycle.
- SB addr 0x13, wd 0x000000A5 -> data_wstrb 1000, data_wdata 0xA5A5A5A5, data_size 0.
- LH addr 0x22, data_rdata 0x8001_7FFF, data_ok 3 cycles late -> readdataM 0x0000_8001 in DONE, stall held through WAIT.
- LW issued, flushM in WAIT -> DRAIN, data_req low, data_ok discarded, readdataM unchanged, next LW proceeds normally.
- LB in DONE with stall_extM high 2 cycles -> DONE held 3 cycles, no second data_req, readdataM stable.
- LW addr 0x21 with DSRAM_ALIGN_CHECK_EN -> adelM 1-cycle pulse, data_req never high; without macro -> data_addr 0x20 issued.

Source files
------------

// File: rtl/data_sram_bridge_pkg.sv
// Shared encodings for the M-stage data SRAM bridge: FSM states, size codes, strobes.
// Latency: n/a (constants and pure helpers only).
// Backpressure: n/a.
package data_sram_bridge_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic [1:0] store_size(input logic [3:0] wen);
        case (wen)
            STRB_B:  return SZ_BYTE;
            STRB_H:  return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

    // Natural alignment of the low address bits for a given access size.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dsram_lane_align.sv
// Byte-lane steering: store strobe/data replication and load data right-justification.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module dsram_lane_align
    import data_sram_bridge_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    st_size,
    input  logic [3:0]    st_wen,
    input  logic [1:0]    st_lo,
    input  logic [DW-1:0] st_data,
    output logic [3:0]    wstrb,
    output logic [DW-1:0] wdata,
    input  logic [1:0]    ld_size,
    input  logic [1:0]    ld_lo,
    input  logic [DW-1:0] rdata_raw,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] rsh;

    assign wstrb = st_wen << st_lo;
    assign rsh   = rdata_raw >> {ld_lo, 3'b000};

    always_comb begin
        case (st_size)
            SZ_BYTE: wdata = {4{st_data[7:0]}};
            SZ_HALF: wdata = {2{st_data[15:0]}};
            default: wdata = st_data;
        endcase
    end

    always_comb begin
        case (ld_size)
            SZ_BYTE: rdata = {{(DW-8){1'b0}}, rsh[7:0]};
            SZ_HALF: rdata = {{(DW-16){1'b0}}, rsh[15:0]};
            default: rdata = rdata_raw;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// M-stage to split-transaction SRAM bus bridge, one transaction per memory instruction.
// Latency: 3 cycles minimum (IDLE+REQ+WAIT), DONE releases the pipeline; stalls until data_ok.
// Backpressure: holds data_req until data_addr_ok; DSRAM_ALIGN_CHECK_EN enables address-error traps.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memenM,
    input  logic [3:0]    mem_wenM,
    input  logic [1:0]    loadsizeM,
    input  logic [AW-1:0] mem_addrM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    input  logic          stall_extM,
    output logic [DW-1:0] readdataM,
    output logic          stall_memM,
    output logic          adelM,
    output logic          adesM,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [3:0]    data_wstrb,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    typedef struct packed {
        logic          wr;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
    } bus_req_t;

    logic [2:0]    state, state_nxt;
    bus_req_t      req_q, req_d;
    logic [DW-1:0] rdata_q;
    logic          is_store, mis_m, issue;
    logic [1:0]    size_m;
    logic [AW-1:0] addr_m;
    logic [3:0]    wstrb_m;
    logic [DW-1:0] wdata_m, rdata_al;

    assign is_store = |mem_wenM;
    // Load size 3 is not a legal encoding; treat it as a word.
    assign size_m   = is_store ? store_size(mem_wenM) : (loadsizeM[1] ? SZ_WORD : loadsizeM);

`ifdef DSRAM_ALIGN_CHECK_EN
    assign mis_m  = misaligned(size_m, mem_addrM[1:0]);
    assign addr_m = mem_addrM;
    assign adelM  = (state == ST_IDLE) & memenM & ~flushM & mis_m & ~is_store;
    assign adesM  = (state == ST_IDLE) & memenM & ~flushM & mis_m & is_store;
`else
    assign mis_m  = 1'b0;
    assign addr_m = {mem_addrM[AW-1:2], align_lo(size_m, mem_addrM[1:0])};
    assign adelM  = 1'b0;
    assign adesM  = 1'b0;
`endif

    assign issue = (state == ST_IDLE) & memenM & ~flushM & ~mis_m;

    dsram_lane_align #(.DW(DW)) u_lane (
        .st_size   (size_m),
        .st_wen    (mem_wenM),
        .st_lo     (addr_m[1:0]),
        .st_data   (writedataM),
        .wstrb     (wstrb_m),
        .wdata     (wdata_m),
        .ld_size   (req_q.size),
        .ld_lo     (req_q.addr[1:0]),
        .rdata_raw (data_rdata),
        .rdata     (rdata_al)
    );

    always_comb begin
        req_d.wr    = is_store;
        req_d.size  = size_m;
        req_d.addr  = addr_m;
        req_d.wdata = wdata_m;
        req_d.wstrb = wstrb_m;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue) state_nxt = ST_REQ;
            ST_REQ: begin
                if (data_addr_ok)
                    state_nxt = flushM ? ST_DRAIN : ST_WAIT;
                else if (flushM)
                    state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                // A response arriving with the flush is simply dropped.
                if (data_data_ok)
                    state_nxt = flushM ? ST_IDLE : ST_DONE;
                else if (flushM)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (data_data_ok) state_nxt = ST_IDLE;
            ST_DONE:  if (!stall_extM) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (issue)
                req_q <= req_d;
            if ((state == ST_WAIT) && data_data_ok && !flushM)
                rdata_q <= rdata_al;
        end
    end

    always_comb begin
        case (state)
            ST_IDLE:         stall_memM = memenM & ~mis_m & ~flushM;
            ST_REQ, ST_WAIT: stall_memM = 1'b1;
            default:         stall_memM = 1'b0;
        endcase
    end

    assign readdataM  = rdata_q;
    assign data_req   = (state == ST_REQ);
    assign data_wr    = req_q.wr;
    assign data_size  = req_q.size;
    assign data_addr  = req_q.addr;
    assign data_wdata = req_q.wdata;
    assign data_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed plus randomized bench for data_sram_bridge against a size/offset reference model.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        memenM;
    logic [3:0]  mem_wenM;
    logic [1:0]  loadsizeM;
    logic [31:0] mem_addrM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        stall_extM;
    logic [31:0] readdataM;
    logic        stall_memM;
    logic        adelM;
    logic        adesM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    data_sram_bridge #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .mem_wenM     (mem_wenM),
        .loadsizeM    (loadsizeM),
        .mem_addrM    (mem_addrM),
        .writedataM   (writedataM),
        .flushM       (flushM),
        .stall_extM   (stall_extM),
        .readdataM    (readdataM),
        .stall_memM   (stall_memM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory instruction as the pipeline sees it; the bench plays both the pipeline and the bus.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int alat, input int dlat, input int ext);
        logic [3:0]  wen;
        logic [31:0] eaddr, estrb, ewdata, erd, sh;
        logic        mis, skip;
        int          off, req_cyc, stall_cyc, waited;
        logic        done;

        wen = wr ? ((sz == 2'd0) ? 4'b0001 : (sz == 2'd1) ? 4'b0011 : 4'b1111) : 4'b0000;
        mis = ((sz == 2'd1) && addr[0]) || ((sz == 2'd2) && (addr[1:0] != 2'b00));
`ifdef DSRAM_ALIGN_CHECK_EN
        skip  = mis;
        eaddr = addr;
`else
        skip  = 1'b0;
        eaddr = addr - (addr % (32'd1 << sz));
`endif
        off    = int'(eaddr % 32'd4);
        estrb  = (32'(wen) << off) & 32'hF;
        ewdata = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
        sh     = rd >> (8 * off);
        erd    = (sz == 2'd2) ? sh : (sh & ((32'd1 << (8 << sz)) - 32'd1));

        @(negedge clk);
        memenM     = 1'b1;
        mem_wenM   = wen;
        loadsizeM  = wr ? 2'($urandom_range(0, 2)) : sz;
        mem_addrM  = addr;
        writedataM = wd;
        #1;
        check("idle_stall", 32'(stall_memM), 32'(!skip));
        check("adel", 32'(adelM), 32'(skip & !wr));
        check("ades", 32'(adesM), 32'(skip & wr));

        req_cyc = 0; stall_cyc = 0; waited = 0; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (data_req) begin
                req_cyc++;
                stall_cyc += int'(stall_memM);
                check("req_wr", 32'(data_wr), 32'(wr));
                check("req_size", 32'(data_size), 32'(sz));
                check("req_addr", data_addr, eaddr);
                check("req_wstrb", 32'(data_wstrb), estrb);
                if (wr) check("req_wdata", data_wdata, ewdata);
                if (waited >= alat) begin data_addr_ok = 1'b1; waited = 0; end
                else waited++;
            end else if (stall_memM) begin
                stall_cyc++;
                if (waited >= dlat) begin data_data_ok = 1'b1; data_rdata = rd; end
                else begin waited++; data_rdata = $urandom; end
            end else begin
                done = 1'b1;
            end
        end
        check("timeout", 32'(done), 32'd1);
        check("req_cycles", req_cyc, skip ? 0 : 1 + alat);
        check("stall_cycles", stall_cyc, skip ? 0 : 2 + alat + dlat);
        if (!wr && !skip) check("load_data", readdataM, erd);

        stall_extM = (ext > 0);
        for (int i = 0; i < ext; i++) begin
            @(negedge clk);
            check("hold_stall", 32'(stall_memM), 32'd0);
            check("hold_req", 32'(data_req), 32'd0);
            if (!wr && !skip) check("hold_data", readdataM, erd);
            stall_extM = (i < ext - 1);
        end
        memenM   = 1'b0;
        mem_wenM = 4'b0000;
        #1;
        check("adel_clear", 32'(adelM | adesM), 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        rst = 1'b1; memenM = 1'b0; mem_wenM = 4'b0; loadsizeM = 2'd0; mem_addrM = 32'h0;
        writedataM = 32'h0; flushM = 1'b0; stall_extM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_stall", 32'(stall_memM), 32'd0);
        check("rst_rdata", readdataM, 32'd0);
        check("rst_flags", 32'(adelM | adesM), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_wstrb", 32'(data_wstrb), 32'd0);
        rst = 1'b0;

        // Stray response while idle must be ignored.
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        data_data_ok = 1'b0;
        check("stray_rdata", readdataM, 32'd0);
        check("stray_req", 32'(data_req), 32'd0);

        run_access(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        run_access(1'b1, 2'd0, 32'h13, 32'h000000A5, 32'h0, 0, 0, 0);
        run_access(1'b0, 2'd1, 32'h22, 32'h0, 32'h8001_7FFF, 0, 3, 0);
        run_access(1'b0, 2'd0, 32'h31, 32'h0, 32'h11C3_5577, 1, 0, 2);

        // Flush while waiting for data: drain the response without touching readdataM.
        @(negedge clk);
        prev = readdataM;
        memenM = 1'b1; mem_wenM = 4'b0; loadsizeM = 2'd2; mem_addrM = 32'h40;
        @(negedge clk);
        check("fw_req", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        check("fw_wait_stall", 32'(stall_memM), 32'd1);
        flushM = 1'b1;
        @(negedge clk);
        flushM = 1'b0; memenM = 1'b0;
        #1;
        check("fw_drain_req", 32'(data_req), 32'd0);
        check("fw_drain_stall", 32'(stall_memM), 32'd0);
        @(negedge clk);
        check("fw_drain_req2", 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        @(negedge clk);
        data_data_ok = 1'b0;
        check("fw_rdata_kept", readdataM, prev);
        run_access(1'b0, 2'd2, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        // Flush while the address phase is still pending.
        @(negedge clk);
        memenM = 1'b1; mem_wenM = 4'b0; loadsizeM = 2'd2; mem_addrM = 32'h50;
        @(negedge clk);
        check("fr_req", 32'(data_req), 32'd1);
        flushM = 1'b1;
        @(negedge clk);
        check("fr_req_drop", 32'(data_req), 32'd0);
        flushM = 1'b0; memenM = 1'b0;
        #1;
        check("fr_stall", 32'(stall_memM), 32'd0);

        run_access(1'b0, 2'd2, 32'h21, 32'h0, 32'hA1B2_C3D4, 0, 0, 0);

        // Reset in the middle of a transaction, then a stray data_ok.
        @(negedge clk);
        memenM = 1'b1; mem_wenM = 4'b0; loadsizeM = 2'd2; mem_addrM = 32'h60;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; rst = 1'b1; memenM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_rdata", readdataM, 32'd0);
        check("mrst_stall", 32'(stall_memM), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        @(negedge clk);
        data_data_ok = 1'b0;
        check("mrst_stray", readdataM, 32'd0);
        check("mrst_req", 32'(data_req), 32'd0);

        for (int k = 0; k < 40; k++) begin
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom,
                       $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
